// File: rtl/os_systolic_array_param.sv
// Output-stationary systolic matrix multiplier, C = A x B, with a runtime inner
// dimension. Unskewed A columns and B rows come in over a valid/ready handshake.
// The diagonal skew is applied internally. Finished columns drain into a
// first-word-fall-through FIFO.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for an accepted start; done pulses here after a job
// CLEAR | zero the accumulators; k_len already latched into beat_cnt
// FEED  | accept operand beats until k_len have been taken
// FLUSH | let the last beat ripple through the array (ROWS+COLS-1 cycles)
// DRAIN | push one result column per cycle into the output FIFO
module os_systolic_array_param #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int K_MAX  = 256,
    parameter int SIGNED = 0,
    parameter int K_W    = $clog2(K_MAX) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [K_W-1:0]           k_len,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ROWS*DATA_W-1:0]   a_vec,
    input  logic [COLS*DATA_W-1:0]   b_vec,
    output logic                     busy,
    output logic                     done,
    output logic                     out_valid,
    input  logic                     out_rd_en,
    output logic [ROWS*ACC_W-1:0]    out_data
);

    localparam int FL_W       = $clog2(ROWS + COLS);
    localparam int CI_W       = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CNT_W      = $clog2(COLS + 1);
    localparam int FLUSH_LAST = ROWS + COLS - 2;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        FLUSH,
        DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [K_W-1:0]   beat_cnt;
    logic [FL_W-1:0]  flush_cnt;
    logic [CI_W-1:0]  col_idx;
    logic             done_q;

    logic             start_ok;
    logic             accept;
    logic             clear_acc;
    logic             load_beat;
    logic             load_flush;
    logic             push;
    logic             drain_last;
    logic             pop;

    logic [DATA_W-1:0] a_inj  [ROWS];
    logic [DATA_W-1:0] b_inj  [COLS];
    logic [DATA_W-1:0] a_skew [ROWS];
    logic [DATA_W-1:0] b_skew [COLS];
    logic [DATA_W-1:0] a_pe   [ROWS][COLS];
    logic [DATA_W-1:0] b_pe   [ROWS][COLS];
    logic [ACC_W-1:0]  acc    [ROWS][COLS];

    logic [ROWS*ACC_W-1:0] fifo_mem [COLS];
    logic [ROWS*ACC_W-1:0] push_word;
    logic [ROWS*ACC_W-1:0] last_q;
    logic [CI_W-1:0]       wr_ptr;
    logic [CI_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]      fifo_cnt;

    // Full-width product, sign- or zero-extended to the accumulator width.
    function automatic logic [ACC_W-1:0] mul_ext(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        logic [2*DATA_W-1:0] p_s;
        logic [2*DATA_W-1:0] p_u;
        p_s = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
        p_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        if (SIGNED != 0) begin
            mul_ext = ACC_W'($signed(p_s));
        end else begin
            mul_ext = ACC_W'(p_u);
        end
    endfunction

    assign start_ok  = start && (fifo_cnt == '0) && (k_len != '0) &&
                       (k_len <= K_W'(K_MAX));
    assign accept    = in_valid && (state_q == FEED);
    assign pop       = out_rd_en && (fifo_cnt != '0);

    assign in_ready  = (state_q == FEED);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign out_valid = (fifo_cnt != '0);
    assign out_data  = (fifo_cnt != '0) ? fifo_mem[rd_ptr] : last_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state control strobes.
    always_comb begin
        state_d    = state_q;
        clear_acc  = 1'b0;
        load_beat  = 1'b0;
        load_flush = 1'b0;
        push       = 1'b0;
        drain_last = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d   = CLEAR;
                    load_beat = 1'b1;
                end
            end
            CLEAR: begin
                clear_acc = 1'b1;
                state_d   = FEED;
            end
            FEED: begin
                if (accept && (beat_cnt == K_W'(1))) begin
                    state_d    = FLUSH;
                    load_flush = 1'b1;
                end
            end
            FLUSH: begin
                if (flush_cnt == '0) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                push = 1'b1;
                if (col_idx == CI_W'(COLS - 1)) begin
                    state_d    = IDLE;
                    drain_last = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Beat and flush down-counters, drain column index and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            flush_cnt <= '0;
            col_idx   <= '0;
            done_q    <= 1'b0;
        end else begin
            if (load_beat) begin
                beat_cnt <= k_len;
            end else if (accept) begin
                beat_cnt <= beat_cnt - K_W'(1);
            end

            if (load_flush) begin
                flush_cnt <= FL_W'(FLUSH_LAST);
            end else if ((state_q == FLUSH) && (flush_cnt != '0)) begin
                flush_cnt <= flush_cnt - FL_W'(1);
            end

            if ((state_q == DRAIN) && !drain_last) begin
                col_idx <= col_idx + CI_W'(1);
            end else begin
                col_idx <= '0;
            end

            done_q <= drain_last;
        end
    end

    // Lane injection: an accepted beat enters the skew lines, anything else is a zero bubble.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            a_inj[r] = accept ? a_vec[r*DATA_W +: DATA_W] : '0;
        end
        for (int c = 0; c < COLS; c++) begin
            b_inj[c] = accept ? b_vec[c*DATA_W +: DATA_W] : '0;
        end
    end

    // A lane r is delayed r cycles before the edge PE register.
    for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
        if (r == 0) begin : g_direct
            assign a_skew[r] = a_inj[r];
        end else begin : g_dly
            logic [DATA_W-1:0] dly [r];
            // Shift line for this lane.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < r; i++) dly[i] <= '0;
                end else begin
                    dly[0] <= a_inj[r];
                    for (int i = 1; i < r; i++) dly[i] <= dly[i-1];
                end
            end
            assign a_skew[r] = dly[r-1];
        end
    end

    // B lane c is delayed c cycles before the edge PE register.
    for (genvar c = 0; c < COLS; c++) begin : g_b_skew
        if (c == 0) begin : g_direct
            assign b_skew[c] = b_inj[c];
        end else begin : g_dly
            logic [DATA_W-1:0] dly [c];
            // Shift line for this lane.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < c; i++) dly[i] <= '0;
                end else begin
                    dly[0] <= b_inj[c];
                    for (int i = 1; i < c; i++) dly[i] <= dly[i-1];
                end
            end
            assign b_skew[c] = dly[c-1];
        end
    end

    // PE grid: operands march right/down, each PE accumulates its own product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    a_pe[r][c] <= '0;
                    b_pe[r][c] <= '0;
                    acc[r][c]  <= '0;
                end
            end
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                a_pe[r][0] <= a_skew[r];
                for (int c = 1; c < COLS; c++) begin
                    a_pe[r][c] <= a_pe[r][c-1];
                end
            end
            for (int c = 0; c < COLS; c++) begin
                b_pe[0][c] <= b_skew[c];
                for (int r = 1; r < ROWS; r++) begin
                    b_pe[r][c] <= b_pe[r-1][c];
                end
            end
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (clear_acc) begin
                        acc[r][c] <= '0;
                    end else begin
                        acc[r][c] <= acc[r][c] + mul_ext(a_pe[r][c], b_pe[r][c]);
                    end
                end
            end
        end
    end

    // Column selected for the current drain cycle.
    always_comb begin
        push_word = '0;
        for (int r = 0; r < ROWS; r++) begin
            push_word[r*ACC_W +: ACC_W] = acc[r][col_idx];
        end
    end

    // Output FIFO; last_q keeps the most recently popped word visible once empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < COLS; i++) fifo_mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            last_q   <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= push_word;
                wr_ptr <= (wr_ptr == CI_W'(COLS - 1)) ? '0 : wr_ptr + CI_W'(1);
            end
            if (pop) begin
                last_q <= fifo_mem[rd_ptr];
                rd_ptr <= (rd_ptr == CI_W'(COLS - 1)) ? '0 : rd_ptr + CI_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_os_systolic_array_param.sv
// Bench for os_systolic_array_param: one unsigned and one signed instance share
// the stimulus. Expected result words go into per-instance queues when a job is
// issued, and a monitor pops and compares them as the FIFO is read.
module tb_os_systolic_array_param;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int DW   = 8;
    localparam int AW   = 32;
    localparam int KM   = 256;
    localparam int KW   = 9;

    typedef logic [ROWS*AW-1:0] word_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [KW-1:0]     k_len = '0;
    logic              in_valid = 1'b0;
    logic [ROWS*DW-1:0] a_vec = '0;
    logic [COLS*DW-1:0] b_vec = '0;
    logic              out_rd_en = 1'b0;

    logic in_ready_u, busy_u, done_u, out_valid_u;
    logic in_ready_s, busy_s, done_s, out_valid_s;
    word_t out_data_u, out_data_s;

    os_systolic_array_param #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .ACC_W(AW),
                              .K_MAX(KM), .SIGNED(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready_u), .a_vec(a_vec), .b_vec(b_vec),
        .busy(busy_u), .done(done_u), .out_valid(out_valid_u),
        .out_rd_en(out_rd_en), .out_data(out_data_u));

    os_systolic_array_param #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .ACC_W(AW),
                              .K_MAX(KM), .SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready_s), .a_vec(a_vec), .b_vec(b_vec),
        .busy(busy_s), .done(done_s), .out_valid(out_valid_s),
        .out_rd_en(out_rd_en), .out_data(out_data_s));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] a_m [ROWS][KM];
    logic [7:0] b_m [KM][COLS];
    word_t q_u[$];
    word_t q_s[$];
    word_t last_u = '0;
    word_t last_s = '0;
    int errors = 0;
    int checks = 0;
    int rdy_cnt = 0;

    task automatic check(input string nm, input logic [ROWS*AW-1:0] act,
                         input logic [ROWS*AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic set_uniform(input logic [7:0] av, input logic [7:0] bv, input int k);
        for (int i = 0; i < k; i++) begin
            for (int r = 0; r < ROWS; r++) a_m[r][i] = av;
            for (int c = 0; c < COLS; c++) b_m[i][c] = bv;
        end
    endtask

    task automatic set_random(input int k);
        for (int i = 0; i < k; i++) begin
            for (int r = 0; r < ROWS; r++) a_m[r][i] = 8'($urandom);
            for (int c = 0; c < COLS; c++) b_m[i][c] = 8'($urandom);
        end
    endtask

    task automatic push_const(input logic [31:0] lane_u, input logic [31:0] lane_s);
        word_t wu, ws;
        for (int r = 0; r < ROWS; r++) begin
            wu[r*AW +: AW] = lane_u;
            ws[r*AW +: AW] = lane_s;
        end
        for (int j = 0; j < COLS; j++) begin
            q_u.push_back(wu);
            q_s.push_back(ws);
        end
    endtask

    function automatic logic [31:0] gold(input int r, input int c, input int k, input bit sgn);
        int s;
        int pa, pb;
        s = 0;
        for (int i = 0; i < k; i++) begin
            if (sgn) begin
                pa = int'($signed(a_m[r][i]));
                pb = int'($signed(b_m[i][c]));
            end else begin
                pa = int'(a_m[r][i]);
                pb = int'(b_m[i][c]);
            end
            s = s + pa * pb;
        end
        return s;
    endfunction

    task automatic push_model(input int k);
        word_t wu, ws;
        for (int j = 0; j < COLS; j++) begin
            for (int r = 0; r < ROWS; r++) begin
                wu[r*AW +: AW] = gold(r, j, k, 1'b0);
                ws[r*AW +: AW] = gold(r, j, k, 1'b1);
            end
            q_u.push_back(wu);
            q_s.push_back(ws);
        end
    endtask

    task automatic drive_beat(input int idx);
        for (int r = 0; r < ROWS; r++) a_vec[r*DW +: DW] = a_m[r][idx];
        for (int c = 0; c < COLS; c++) b_vec[c*DW +: DW] = b_m[idx][c];
    endtask

    task automatic pulse_start(input int k);
        @(posedge clk); #1;
        k_len = KW'(k);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_job(input int k, input bit bubbles, input bit chk_lat);
        int idx, budget, t_first, t_done, t_ov;
        pulse_start(k);
        rdy_cnt = 0;
        idx = 0;
        budget = 0;
        t_first = -1;
        while (idx < k && budget < 4 * k + 64) begin
            if (bubbles && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                drive_beat(idx);
            end
            @(negedge clk);
            if (budget == 0) check("busy_after_start", busy_u, 1);
            if (in_valid && in_ready_u) begin
                if (idx == 0) t_first = cyc;
                idx++;
            end
            @(posedge clk); #1;
            budget++;
        end
        in_valid = 1'b0;
        a_vec = '0;
        b_vec = '0;
        check("beats_accepted", idx, k);
        t_done = -1;
        t_ov = -1;
        for (int n = 0; n < k + 64; n++) begin
            @(negedge clk);
            if (t_ov < 0 && out_valid_u) t_ov = cyc;
            if (done_u) begin
                t_done = cyc;
                break;
            end
        end
        check("done_seen", (t_done >= 0), 1);
        check("done_s_at_done", done_s, 1);
        check("busy_low_at_done", busy_u, 0);
        if (chk_lat) begin
            check("done_latency", t_done, t_first + k + ROWS + 2 * COLS - 1);
            check("first_valid", t_ov, t_first + k + ROWS + COLS);
        end
        @(negedge clk);
        check("done_single", done_u, 0);
    endtask

    task automatic drain();
        @(posedge clk); #1;
        out_rd_en = 1'b1;
        for (int n = 0; n < 4 * COLS; n++) begin
            @(negedge clk);
            if (!out_valid_u && !out_valid_s) break;
        end
        out_rd_en = 1'b0;
        check("fifo_emptied", {out_valid_u, out_valid_s}, 0);
        check("sb_empty_u", q_u.size(), 0);
        check("sb_empty_s", q_s.size(), 0);
        @(negedge clk);
        check("hold_u", out_data_u, last_u);
        check("hold_s", out_data_s, last_s);
    endtask

    initial begin
        word_t wu, ws;
        fork
            forever begin
                @(negedge clk);
                if (in_ready_u) rdy_cnt++;
                if (out_valid_u && out_rd_en) begin
                    if (q_u.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pop_u: actual=%0h required=none", out_data_u);
                    end else begin
                        last_u = q_u.pop_front();
                        check("pop_u", out_data_u, last_u);
                    end
                end
                if (out_valid_s && out_rd_en) begin
                    if (q_s.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pop_s: actual=%0h required=none", out_data_s);
                    end else begin
                        last_s = q_s.pop_front();
                        check("pop_s", out_data_s, last_s);
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy_u, 0);
        check("rst_in_ready", in_ready_u, 0);
        check("rst_out_valid", out_valid_u, 0);
        check("rst_done", done_u, 0);
        check("rst_out_data_u", out_data_u, 0);
        check("rst_out_data_s", out_data_s, 0);
        rst_n = 1'b1;

        // All 255, K=8
        set_uniform(8'hFF, 8'hFF, 8);
        push_const(32'h0007_F008, 32'h0000_0008);
        run_job(8, 1'b0, 1'b1);
        drain();

        // Identity A, random B
        set_random(8);
        for (int i = 0; i < 8; i++)
            for (int r = 0; r < ROWS; r++) a_m[r][i] = (r == i) ? 8'd1 : 8'd0;
        for (int j = 0; j < COLS; j++) begin
            for (int r = 0; r < ROWS; r++) begin
                wu[r*AW +: AW] = {24'h0, b_m[r][j]};
                ws[r*AW +: AW] = {{24{b_m[r][j][7]}}, b_m[r][j]};
            end
            q_u.push_back(wu);
            q_s.push_back(ws);
        end
        run_job(8, 1'b0, 1'b1);
        check("ready_cycles", rdy_cnt, 8);
        drain();

        // -128 x -128 and -1 x 1
        set_uniform(8'h80, 8'h80, 8);
        push_const(32'h0002_0000, 32'h0002_0000);
        run_job(8, 1'b0, 1'b1);
        drain();
        set_uniform(8'hFF, 8'h01, 8);
        push_const(32'h0000_07F8, 32'hFFFF_FFF8);
        run_job(8, 1'b0, 1'b1);
        drain();

        // Random job with bubbles; start while FIFO full is ignored
        set_random(8);
        push_model(8);
        run_job(8, 1'b1, 1'b0);
        check("full_out_valid", out_valid_u, 1);
        pulse_start(8);
        @(negedge clk);
        check("start_full_ignored_u", busy_u, 0);
        check("start_full_ignored_s", busy_s, 0);
        check("full_still_valid", out_valid_u, 1);
        drain();

        // Invalid k_len starts are ignored
        pulse_start(0);
        @(negedge clk);
        check("k0_ignored", busy_u, 0);
        pulse_start(257);
        @(negedge clk);
        check("k257_ignored", busy_u, 0);

        // K=1 and K=256
        set_uniform(8'hFF, 8'hFF, 1);
        push_const(32'h0000_FE01, 32'h0000_0001);
        run_job(1, 1'b0, 1'b1);
        drain();
        set_uniform(8'hFF, 8'hFF, 256);
        push_const(32'h00FE_0100, 32'h0000_0100);
        run_job(256, 1'b0, 1'b1);
        drain();

        // Reset mid-FEED, then a clean job
        set_uniform(8'h7F, 8'h7F, 8);
        pulse_start(8);
        in_valid = 1'b1;
        drive_beat(0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy_u, 0);
        check("midrst_in_ready", in_ready_u, 0);
        check("midrst_out_valid", out_valid_u, 0);
        check("midrst_done", done_u, 0);
        check("midrst_out_data", out_data_u, 0);
        in_valid = 1'b0;
        a_vec = '0;
        b_vec = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        set_random(8);
        push_model(8);
        run_job(8, 1'b0, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
